// File: rtl/v3a_sched_pkg.sv
// Shared types for the v3a queue-controller scheduler: op codes, FSM states
// and small op-classification helpers.
package v3a_sched_pkg;

  typedef enum logic [2:0] {
    OP_ENQ_BACK  = 3'd0,
    OP_ENQ_FRONT = 3'd1,
    OP_DEQ_BACK  = 3'd2,
    OP_DEQ_FRONT = 3'd3,
    OP_UPD       = 3'd4,
    OP_DEL       = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic logic is_enq(input logic [2:0] op);
    return (op == OP_ENQ_BACK) || (op == OP_ENQ_FRONT);
  endfunction

  function automatic logic is_deq(input logic [2:0] op);
    return (op == OP_DEQ_BACK) || (op == OP_DEQ_FRONT);
  endfunction

  function automatic logic is_valid_op(input logic [2:0] op);
    return op <= OP_DEL;
  endfunction

endpackage

// File: rtl/v3a_rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts at ptr, and ptr moves to
// winner+1 whenever the caller accepts the grant.
module v3a_rr_arbiter #(
  parameter  int p_num = 4,
  localparam int iw    = $clog2(p_num)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [p_num-1:0] req,
  input  logic             advance,
  output logic [p_num-1:0] grant,
  output logic [iw-1:0]    idx,
  output logic             any
);

  logic [iw-1:0] ptr;

  // NOTE: every output gets a default before the loop so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    int            j;
    logic [iw-1:0] jj;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < p_num; i++) begin
      j  = (int'(ptr) + i) % p_num;
      jj = iw'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        idx       = jj;
        grant[jj] = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (idx == iw'(p_num - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/v3a_op_sched.sv
// Shares one v3a queue controller between p_num_req requesters: round-robin
// accept, per-op enable discipline, completion wait with watchdog, response.
module v3a_op_sched
  import v3a_sched_pkg::*;
#(
  parameter int p_num_req   = 4,
  parameter int p_depth     = 32,
  parameter int p_ptrwidth  = $clog2(p_depth),
  parameter int p_chanwidth = 32,
  parameter int p_timeout   = 2 * p_depth + 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_req-1:0]                  req_val,
  output logic [p_num_req-1:0]                  req_rdy,
  input  logic [p_num_req-1:0][2:0]             req_op,
  input  logic [p_num_req-1:0][p_ptrwidth-1:0]  req_tag,
  input  logic [p_num_req-1:0][p_chanwidth-1:0] req_data,
  output logic [p_num_req-1:0]                  resp_val,
  output logic [p_ptrwidth-1:0]                 resp_tag,
  output logic [p_chanwidth-1:0]                resp_data,
  output logic                                  resp_err,
  output logic                                  enq_back_en,
  output logic                                  enq_front_en,
  output logic                                  deq_back_en,
  output logic                                  deq_front_en,
  output logic                                  upd_en,
  output logic                                  del_en,
  input  logic                                  enq_back_cpl,
  input  logic                                  enq_front_cpl,
  input  logic                                  deq_back_cpl,
  input  logic                                  deq_front_cpl,
  input  logic                                  upd_cpl,
  input  logic                                  del_cpl,
  input  logic [p_ptrwidth-1:0]                 enq_back_tag_out,
  input  logic [p_ptrwidth-1:0]                 enq_front_tag_out,
  input  logic [p_chanwidth-1:0]                deq_back_data,
  input  logic [p_chanwidth-1:0]                deq_front_data,
  output logic [p_chanwidth-1:0]                q_op_data,
  output logic [p_ptrwidth-1:0]                 q_op_tag
);

  localparam int iw   = $clog2(p_num_req);
  localparam int cw   = p_ptrwidth + 1;
  localparam int wd_w = $clog2(p_timeout + 1);
  localparam logic [cw-1:0] full_c = cw'(p_depth);

  state_e                   state;
  logic [2:0]               op_q;
  logic [p_ptrwidth-1:0]    op_tag;
  logic [p_chanwidth-1:0]   op_data;
  logic [iw-1:0]            winner;
  logic [p_num_req-1:0]     winner_oh;
  logic [cw-1:0]            count;
  logic [wd_w-1:0]          wd;

  logic [p_num_req-1:0]     grant;
  logic [iw-1:0]            gidx;
  logic                     any_req, accept, busy, reject, timeout, cpl_hit;
  logic [2:0]               op_in;
  logic [p_ptrwidth-1:0]    cpl_tag;
  logic [p_chanwidth-1:0]   cpl_data;

  assign accept    = (state == S_IDLE) && any_req;
  assign req_rdy   = accept ? grant : '0;
  assign busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign timeout   = busy && (wd == wd_w'(p_timeout - 1));
  assign q_op_data = op_data;
  assign q_op_tag  = op_tag;

  v3a_rr_arbiter #(.p_num(p_num_req)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_val),
    .advance (accept),
    .grant   (grant),
    .idx     (gidx),
    .any     (any_req)
  );

  always_comb begin
    op_in     = req_op[gidx];
    reject    = !is_valid_op(op_in)
              || ( is_enq(op_in) && (count == full_c))
              || (!is_enq(op_in) && (count == '0));
    winner_oh = '0;
    winner_oh[winner] = 1'b1;
  end

  // enq/deq fire only in ISSUE; upd/del hold through the search and drop
  // combinationally in the completion cycle so no second search starts.
  always_comb begin
    enq_back_en  = (state == S_ISSUE) && (op_q == OP_ENQ_BACK);
    enq_front_en = (state == S_ISSUE) && (op_q == OP_ENQ_FRONT);
    deq_back_en  = (state == S_ISSUE) && (op_q == OP_DEQ_BACK);
    deq_front_en = (state == S_ISSUE) && (op_q == OP_DEQ_FRONT);
    upd_en       = busy && (op_q == OP_UPD) && !upd_cpl;
    del_en       = busy && (op_q == OP_DEL) && !del_cpl;
  end

  always_comb begin
    cpl_hit  = 1'b0;
    cpl_tag  = '0;
    cpl_data = '0;
    case (op_q)
      OP_ENQ_BACK: begin
        cpl_hit = (state == S_WAIT) && enq_back_cpl;
        cpl_tag = enq_back_tag_out;
      end
      OP_ENQ_FRONT: begin
        cpl_hit = (state == S_WAIT) && enq_front_cpl;
        cpl_tag = enq_front_tag_out;
      end
      OP_DEQ_BACK: begin
        cpl_hit  = (state == S_WAIT) && deq_back_cpl;
        cpl_data = deq_back_data;
      end
      OP_DEQ_FRONT: begin
        cpl_hit  = (state == S_WAIT) && deq_front_cpl;
        cpl_data = deq_front_data;
      end
      OP_UPD:  cpl_hit = busy && upd_cpl;
      OP_DEL:  cpl_hit = busy && del_cpl;
      default: cpl_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      op_tag    <= '0;
      op_data   <= '0;
      winner    <= '0;
      count     <= '0;
      wd        <= '0;
      resp_val  <= '0;
      resp_err  <= 1'b0;
      resp_tag  <= '0;
      resp_data <= '0;
    end else begin
      resp_val <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            op_q    <= op_in;
            op_tag  <= req_tag[gidx];
            op_data <= req_data[gidx];
            winner  <= gidx;
            wd      <= '0;
            if (reject) begin
              state     <= S_RESP;
              resp_val  <= grant;
              resp_err  <= 1'b1;
              resp_tag  <= '0;
              resp_data <= '0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          wd <= wd + 1'b1;
          if (cpl_hit) begin
            state     <= S_RESP;
            resp_val  <= winner_oh;
            resp_err  <= 1'b0;
            resp_tag  <= cpl_tag;
            resp_data <= cpl_data;
            if (is_enq(op_q) && (count != full_c)) begin
              count <= count + 1'b1;
            end else if ((is_deq(op_q) || (op_q == OP_DEL)) && (count != '0)) begin
              count <= count - 1'b1;
            end
          end else if (timeout) begin
            // A lost completion leaves occupancy untouched; only the error is reported.
            state     <= S_RESP;
            resp_val  <= winner_oh;
            resp_err  <= 1'b1;
            resp_tag  <= '0;
            resp_data <= '0;
          end else begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v3a_op_sched.sv
// Self-checking bench for v3a_op_sched: a behavioural controller stub, a
// vector table plus hand sequences, and a response scoreboard.
module tb_v3a_op_sched;
  import v3a_sched_pkg::*;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int TW = $clog2(D);
  localparam int DW = 32;
  localparam int TO = 2 * D + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]          req_val = '0;
  logic [N-1:0]          req_rdy;
  logic [N-1:0][2:0]     req_op = '0;
  logic [N-1:0][TW-1:0]  req_tag = '0;
  logic [N-1:0][DW-1:0]  req_data = '0;
  logic [N-1:0]          resp_val;
  logic [TW-1:0]         resp_tag;
  logic [DW-1:0]         resp_data;
  logic                  resp_err;
  logic enq_back_en, enq_front_en, deq_back_en, deq_front_en, upd_en, del_en;
  logic enq_back_cpl, enq_front_cpl, deq_back_cpl, deq_front_cpl, upd_cpl, del_cpl;
  logic [TW-1:0]         tag_r;
  logic [DW-1:0]         data_r;
  logic [DW-1:0]         q_op_data;
  logic [TW-1:0]         q_op_tag;
  logic [5:0]            en_vec;

  v3a_op_sched #(.p_num_req(N), .p_depth(D), .p_chanwidth(DW)) u_dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_tag(req_tag), .req_data(req_data),
    .resp_val(resp_val), .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err),
    .enq_back_en(enq_back_en), .enq_front_en(enq_front_en), .deq_back_en(deq_back_en),
    .deq_front_en(deq_front_en), .upd_en(upd_en), .del_en(del_en),
    .enq_back_cpl(enq_back_cpl), .enq_front_cpl(enq_front_cpl), .deq_back_cpl(deq_back_cpl),
    .deq_front_cpl(deq_front_cpl), .upd_cpl(upd_cpl), .del_cpl(del_cpl),
    .enq_back_tag_out(tag_r), .enq_front_tag_out(tag_r),
    .deq_back_data(data_r), .deq_front_data(data_r),
    .q_op_data(q_op_data), .q_op_tag(q_op_tag)
  );

  always #5 clk = ~clk;
  assign en_vec = {enq_back_en, enq_front_en, deq_back_en, deq_front_en, upd_en, del_en};

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Controller stub: enq/deq complete one cycle after the enable; upd/del
  // complete after search_len consecutive enable cycles. mute kills all cpls.
  bit            mute = 1'b0;
  int            search_len = 2;
  logic [TW-1:0] stub_tag;
  logic [DW-1:0] stub_q[$];
  logic          pend_eb, pend_ef, pend_db, pend_df;
  int            ucnt, dcnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_eb <= 1'b0; pend_ef <= 1'b0; pend_db <= 1'b0; pend_df <= 1'b0;
      stub_tag <= '0; tag_r <= '0; data_r <= '0; ucnt <= 0; dcnt <= 0;
      stub_q.delete();
    end else begin
      pend_eb <= enq_back_en;  pend_ef <= enq_front_en;
      pend_db <= deq_back_en;  pend_df <= deq_front_en;
      if (enq_back_en || enq_front_en) begin
        tag_r    <= stub_tag;
        stub_tag <= stub_tag + 1'b1;
      end
      if (enq_back_en)  stub_q.push_back(q_op_data);
      if (enq_front_en) stub_q.push_front(q_op_data);
      if (deq_back_en  && stub_q.size() > 0) data_r <= stub_q.pop_back();
      if (deq_front_en && stub_q.size() > 0) data_r <= stub_q.pop_front();
      ucnt <= upd_en ? ucnt + 1 : 0;
      dcnt <= del_en ? dcnt + 1 : 0;
    end
  end

  assign enq_back_cpl  = pend_eb && !mute;
  assign enq_front_cpl = pend_ef && !mute;
  assign deq_back_cpl  = pend_db && !mute;
  assign deq_front_cpl = pend_df && !mute;
  assign upd_cpl       = !mute && (search_len > 0) && (ucnt == search_len);
  assign del_cpl       = !mute && (search_len > 0) && (dcnt == search_len);

  typedef struct {
    int            idx;
    logic [2:0]    op;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          err;
    logic [TW-1:0] etag;
    logic [DW-1:0] edata;
    int            lat;
    int            en;
    int            cnt;
  } vec_t;

  typedef struct {
    int            idx;
    logic          err;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            lat;
    int            en;
    int            acc;
  } item_t;

  item_t sb[$];
  int    grant_order[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    en_cnt = 0;
  int    upd_cpl_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic vec_t mk(int idx, int op, int tag, int data, int err,
                              int etag, int edata, int lat, int en, int cnt);
    vec_t v;
    v.idx = idx; v.op = 3'(op); v.tag = TW'(tag); v.data = DW'(data);
    v.err = 1'(err); v.etag = TW'(etag); v.edata = DW'(edata);
    v.lat = lat; v.en = en; v.cnt = cnt;
    return v;
  endfunction

  always @(negedge clk) begin : mon
    item_t it;
    if (rst) begin
      if (|en_vec) en_cnt++;
      if (upd_cpl) begin
        upd_cpl_total++;
        check("upd_en_low_in_cpl", 64'(upd_en), 64'(0));
      end
      if (del_cpl) check("del_en_low_in_cpl", 64'(del_en), 64'(0));
      if (|resp_val) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          it = sb.pop_front();
          check($sformatf("resp_val_req%0d", it.idx), 64'(resp_val), 64'(1) << it.idx);
          check($sformatf("resp_err_req%0d", it.idx), 64'(resp_err), 64'(it.err));
          check($sformatf("resp_tag_req%0d", it.idx), 64'(resp_tag), 64'(it.tag));
          check($sformatf("resp_data_req%0d", it.idx), 64'(resp_data), 64'(it.data));
          check($sformatf("latency_req%0d", it.idx), 64'(cyc - it.acc), 64'(it.lat));
          check($sformatf("en_cycles_req%0d", it.idx), 64'(en_cnt), 64'(it.en));
        end
      end
    end
  end

  task automatic do_req(input vec_t v);
    int    n;
    item_t it;
    req_op[v.idx]   = v.op;
    req_tag[v.idx]  = v.tag;
    req_data[v.idx] = v.data;
    req_val[v.idx]  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_rdy[v.idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy[v.idx]) begin
      req_val[v.idx] = 1'b0;
      fail_now($sformatf("rdy_wait_req%0d", v.idx));
      return;
    end
    it.idx = v.idx; it.err = v.err; it.tag = v.etag; it.data = v.edata;
    it.lat = v.lat; it.en = v.en; it.acc = cyc;
    sb.push_back(it);
    en_cnt = 0;
    grant_order.push_back(v.idx);
    @(posedge clk);
    #1 req_val[v.idx] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_val[v.idx] && n < 200);
    if (!resp_val[v.idx]) fail_now($sformatf("resp_wait_req%0d", v.idx));
    else if (v.cnt >= 0) check($sformatf("count_after_req%0d", v.idx), 64'(u_dut.count), 64'(v.cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req_val = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  vec_t vecs[14];
  vec_t fvec[4];

  initial begin
    // inputs: idx op tag data | expected: err tag data latency en_cycles count
    vecs[0]  = mk(0, 0, 0, 'hA5, 0, 0, 0,     3, 1, 1);
    vecs[1]  = mk(1, 0, 0, 'h11, 0, 1, 0,     3, 1, 2);
    vecs[2]  = mk(2, 1, 0, 'h22, 0, 2, 0,     3, 1, 3);
    vecs[3]  = mk(3, 0, 0, 'h33, 0, 3, 0,     3, 1, 4);
    vecs[4]  = mk(2, 2, 0, 0,    0, 0, 'h33,  3, 1, 3);
    vecs[5]  = mk(0, 3, 0, 0,    0, 0, 'h22,  3, 1, 2);
    vecs[6]  = mk(1, 4, 3, 'h55, 0, 0, 0,     4, 2, 2);
    vecs[7]  = mk(3, 6, 0, 0,    1, 0, 0,     1, 0, 2);
    vecs[8]  = mk(0, 7, 0, 0,    1, 0, 0,     1, 0, 2);
    vecs[9]  = mk(2, 2, 0, 0,    0, 0, 'h11,  3, 1, 1);
    vecs[10] = mk(3, 5, 1, 0,    0, 0, 0,     4, 2, 0);
    vecs[11] = mk(0, 3, 0, 0,    1, 0, 0,     1, 0, 0);
    vecs[12] = mk(1, 4, 2, 0,    1, 0, 0,     1, 0, 0);
    vecs[13] = mk(2, 5, 0, 0,    1, 0, 0,     1, 0, 0);

    // Reset state
    #12;
    check("rst_req_rdy", 64'(req_rdy), 64'(0));
    check("rst_resp_val", 64'(resp_val), 64'(0));
    check("rst_resp_err", 64'(resp_err), 64'(0));
    check("rst_resp_tag", 64'(resp_tag), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_enables", 64'(en_vec), 64'(0));
    check("rst_q_op_data", 64'(q_op_data), 64'(0));
    check("rst_q_op_tag", 64'(q_op_tag), 64'(0));
    check("rst_count", 64'(u_dut.count), 64'(0));
    check("rst_state", 64'(u_dut.state), 64'(S_IDLE));
    check("rst_rr_ptr", 64'(u_dut.u_arb.ptr), 64'(0));
    apply_reset();

    // Table vectors: enq/deq/upd/del, bad op codes, empty rejects
    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i]);
      if (i == 6) check("upd_cpl_pulses", 64'(upd_cpl_total), 64'(1));
    end

    // Fairness: four enqs, then all requesters ask for deq_back at once
    apply_reset();
    for (int i = 0; i < N; i++) do_req(mk(i, 0, 0, 10 * (i + 1), 0, i, 0, 3, 1, i + 1));
    for (int i = 0; i < N; i++) fvec[i] = mk(i, 2, 0, 0, 0, 0, 10 * (N - i), 3, 1, -1);
    grant_order.delete();
    fork
      do_req(fvec[0]);
      do_req(fvec[1]);
      do_req(fvec[2]);
      do_req(fvec[3]);
    join
    check("grant_count", 64'(grant_order.size()), 64'(N));
    for (int i = 0; i < grant_order.size(); i++)
      check($sformatf("grant_order_%0d", i), 64'(grant_order[i]), 64'(i));
    check("rr_ptr_wrap", 64'(u_dut.u_arb.ptr), 64'(0));
    check("count_after_fair", 64'(u_dut.count), 64'(0));

    // Fill to depth, then enqs are rejected locally with no enable
    for (int i = 0; i < D; i++) do_req(mk(0, 0, 0, 'h100 + i, 0, (N + i) % D, 0, 3, 1, i + 1));
    do_req(mk(1, 0, 0, 'hDEAD, 1, 0, 0, 1, 0, D));
    do_req(mk(2, 1, 0, 'hBEEF, 1, 0, 0, 1, 0, D));

    // Watchdog: completions muted, del held for the full timeout
    apply_reset();
    do_req(mk(0, 0, 0, 'h77, 0, 0, 0, 3, 1, 1));
    mute = 1'b1;
    do_req(mk(1, 5, 0, 0, 1, 0, 0, TO + 1, TO, 1));
    mute = 1'b0;

    // Reset during an upd search drops enables asynchronously
    search_len = 10;
    req_op[0] = 3'(OP_UPD); req_tag[0] = TW'(3); req_data[0] = 'h55; req_val[0] = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!req_rdy[0] && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!req_rdy[0]) fail_now("rdy_wait_reset_upd");
    end
    @(posedge clk);
    #1 req_val[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("upd_en_mid_search", 64'(upd_en), 64'(1));
    rst = 1'b0;
    #1;
    check("async_rst_enables", 64'(en_vec), 64'(0));
    check("async_rst_state", 64'(u_dut.state), 64'(S_IDLE));
    check("async_rst_resp_val", 64'(resp_val), 64'(0));
    check("async_rst_count", 64'(u_dut.count), 64'(0));
    sb.delete();
    search_len = 2;
    @(posedge clk);
    #1 rst = 1'b1;
    do_req(mk(2, 0, 0, 'h99, 0, 0, 0, 3, 1, 1));

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/v3a_op_sched.md
Name: v3a_op_sched

Overview:
- Shares one v3a queue controller between p_num_req requesters.
- Captures each request with a val/rdy handshake and grants one at a time, round-robin.
- Drives the controller's six op-enable lines with each op's enable discipline, waits for the matching completion, then returns a response pulse with tag or data.
- Tracks occupancy so enq to a full queue and deq from an empty queue are rejected locally, and uses a watchdog so a missing completion cannot hang the block.

Parameters:
- p_num_req, 4, number of requesters (≥2).
- p_depth, 32, queue depth of the controlled queue.
- p_ptrwidth, $clog2(p_depth), tag width.
- p_chanwidth, 32, payload width.
- p_timeout, 2*p_depth+4, max cycles to wait for a completion.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_val  in  [p_num_req]  request valid, one per requester
- req_rdy  out  [p_num_req]  one-hot accept pulse
- req_op  in  [p_num_req][3]  op code (package enum)
- req_tag  in  [p_num_req][p_ptrwidth]  tag for upd/del
- req_data  in  [p_num_req][p_chanwidth]  data for enq/upd
- resp_val  out  [p_num_req]  one-hot response pulse
- resp_tag  out  p_ptrwidth  tag returned by enq
- resp_data  out  p_chanwidth  data returned by deq
- resp_err  out  1  rejected (full/empty/bad op) or timed out
- enq_back_en, enq_front_en, deq_back_en, deq_front_en, upd_en, del_en  out  1  controller op enables
- enq_back_cpl, enq_front_cpl, deq_back_cpl, deq_front_cpl, upd_cpl, del_cpl  in  1  controller completions
- enq_back_tag_out, enq_front_tag_out  in  p_ptrwidth  controller tags
- deq_back_data, deq_front_data  in  p_chanwidth  controller data
- q_op_data  out  p_chanwidth  enq/upd data to controller
- q_op_tag  out  p_ptrwidth  upd/del tag to controller

Behaviour:
- Reset (rst=0, async): state IDLE; rr pointer 0; count 0; all req_rdy, resp_val, resp_err, enables, resp_tag, resp_data, q_op_* = 0. Enables drop in the same cycle reset asserts, even mid-search.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick the first asserted req_val starting at the rr pointer.
  - Assert req_rdy[winner] combinationally, capture op/tag/data and the winner index.
  - Set rr pointer to winner+1, mod p_num_req.
  - Go to ISSUE, or go straight to RESP with err=1 when: enq and count==p_depth; deq/upd/del and count==0; or op code >5.
- ISSUE, enq/deq: the one matching enable is high for exactly one cycle, then go to WAIT. This prevents a double fire.
- ISSUE/WAIT, upd/del:
  - upd_en or del_en = (state in {ISSUE, WAIT}) && !matching cpl.
  - The combinational drop in the cpl cycle prevents a second search from starting.
- WAIT:
  - On the matching cpl, capture the tag from the matching enq_*_tag_out and data from the matching deq_*_data (both valid in the cpl cycle).
  - Update count: +1 on enq cpl; −1 on deq cpl; −1 on del cpl.
  - Go to RESP.
- Watchdog: counts cycles spent in ISSUE and WAIT. When it reaches p_timeout, drop the enable, set err=1, leave count unchanged, go to RESP.
- RESP: resp_val[winner]=1 for exactly one cycle, with resp_tag/resp_data/resp_err, then go to IDLE. resp_* are registered and hold their value until the next RESP.
- Nominal latency, counted from the accept cycle (cycle 0):
  - enq/deq: en at cycle 1, cpl at cycle 2, resp_val at cycle 3.
  - upd/del: resp_val one cycle after cpl.
  - Local reject: resp_val at cycle 1.
- Simultaneous req_val from several requesters: exactly one is granted; the others stay pending, and their req_val must be held until rdy.
- count saturates at [0, p_depth]. The arithmetic is p_ptrwidth+1 bits wide.
- At most one request is in flight. req_rdy is 0 outside IDLE.

Decomposition:
- Shared package v3a_sched_pkg: op enum (OP_ENQ_BACK=0, OP_ENQ_FRONT=1, OP_DEQ_BACK=2, OP_DEQ_FRONT=3, OP_UPD=4, OP_DEL=5) and FSM state enum.
- One sub-module, v3a_rr_arbiter: parameterized round-robin one-hot grant with a pointer-advance input.

Test Plan:
- Single enq_back: req0 op=0, data=0xA5 → enq_back_en high for 1 cycle; resp_val[0] at cycle 3; resp_tag = controller tag (0 after reset); count=1.
- Fairness: req0..3 all valid with deq_back after 4 enqs → grants in order 0,1,2,3; rr pointer wraps to 0; each response carries the LIFO data.
- Full reject: p_depth enqs then another enq → resp_val at cycle 1 with err=1; no enable asserted. Empty reject: deq at count 0 → err=1.
- upd of tag 3 with data 0x55 → upd_en held through the search and low in the cpl cycle; exactly one upd_cpl; resp err=0.
- Timeout: cpl inputs tied 0, del issued → del_en high for p_timeout cycles, then resp err=1; count unchanged.
- Reset mid-WAIT of an upd → all enables low asynchronously; after release, IDLE; a new enq completes normally.
